loop_sram_ctrl: RTL and testbench

- Looper controller that owns the external 16-bit async SRAM and sequences one SRAM access per audio sample.
- RECORD writes the incoming effect-chain sample to consecutive addresses. PLAY reads the stored loop back, wrapping at the recorded length, and mixes it with the live sample.
- Sits between the tail of the effect chain and the DAC player. It is driven by the top-level S_RECD_LOOP / S_PLAY_LOOP key commands.

---
 rtl/loop_pkg.sv | 63 ++++++
 rtl/loop_sram_ctrl_if.sv | 27 ++
 rtl/loop_mix_sat.sv | 36 +++
 rtl/loop_sram_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_loop_sram_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loop_pkg.sv
// loop_pkg
//   Shared types and helpers for the looper SRAM controller.
//   - mode_e  : externally visible mode (IDLE / REC / PLAY)
//   - state_e : controller FSM state, including the SRAM access states
//   - cmd_e   : key command, encoded so a larger value means higher priority
//   - SAT_MAX / SAT_MIN and sat16() : 16-bit signed clamp of a 17-bit sum
package loop_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REC      = 3'd1,
        S_REC_WR   = 3'd2,
        S_REC_HOLD = 3'd3,
        S_PLAY     = 3'd4,
        S_PLAY_RD  = 3'd5
    } state_e;

    // Ordered by priority: stop > play > rec > none.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_REC  = 2'd1,
        CMD_PLAY = 2'd2,
        CMD_STOP = 2'd3
    } cmd_e;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    // Overflow of a 17-bit sum shows up as the top two bits disagreeing;
    // the sign bit then tells which rail to clamp to.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x[16] != x[15]) begin
            return x[16] ? SAT_MIN : SAT_MAX;
        end
        return x[15:0];
    endfunction

    function automatic mode_e mode_of(input state_e s);
        case (s)
            S_REC, S_REC_WR, S_REC_HOLD: return MODE_REC;
            S_PLAY, S_PLAY_RD:           return MODE_PLAY;
            default:                     return MODE_IDLE;
        endcase
    endfunction

    function automatic cmd_e cmd_decode(input logic stop, input logic play, input logic rec);
        if (stop) return CMD_STOP;
        if (play) return CMD_PLAY;
        if (rec)  return CMD_REC;
        return CMD_NONE;
    endfunction

    function automatic cmd_e cmd_max(input cmd_e a, input cmd_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/loop_sram_ctrl_if.sv
// loop_sram_ctrl_if
//   Sample stream and key-command bundle between the effect chain, the
//   looper controller and the DAC player.
//   Handshake: i_valid / o_valid are single-cycle strobes with no back
//   pressure; data is qualified only in the cycle its strobe is high.
//   Commands are single-cycle pulses.
//   - master : effect-chain / top-level side (drives samples and commands)
//   - slave  : looper controller side
interface loop_sram_ctrl_if;
    logic               i_valid;
    logic signed [15:0] i_data;
    logic               i_cmd_rec;
    logic               i_cmd_play;
    logic               i_cmd_stop;
    logic               o_valid;
    logic signed [15:0] o_data;

    modport master (
        output i_valid, i_data, i_cmd_rec, i_cmd_play, i_cmd_stop,
        input  o_valid, o_data
    );

    modport slave (
        input  i_valid, i_data, i_cmd_rec, i_cmd_play, i_cmd_stop,
        output o_valid, o_data
    );
endinterface

// File: rtl/loop_mix_sat.sv
// loop_mix_sat
//   Registered 17-bit signed add of two samples followed by a clamp to
//   the 16-bit signed range. Holds its output when i_en is low.
//   Ports: i_AUD_BCLK clock, i_rst_n async active-low reset, i_en load,
//          i_a / i_b signed operands, o_sum registered clamped result.
module loop_mix_sat
    import loop_pkg::*;
(
    input  logic               i_AUD_BCLK,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [15:0] o_sum
);

    logic signed [15:0] sum_q;
    logic signed [15:0] sum_d;
    logic signed [16:0] wide;

    always_comb begin
        wide  = {i_a[15], i_a} + {i_b[15], i_b};
        sum_d = i_en ? sat16(wide) : sum_q;
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o_sum = sum_q;

endmodule

// File: rtl/loop_sram_ctrl.sv
// loop_sram_ctrl
//   Looper controller owning the external 16-bit async SRAM. One SRAM
//   access per audio sample: REC writes the live sample at consecutive
//   addresses, PLAY reads the loop back (wrapping at the recorded length)
//   and mixes it with the live sample. Output is always 2 cycles after
//   the input strobe.
//   Ports:
//     i_AUD_BCLK, i_rst_n   clock, async active-low reset
//     aud                   sample stream + key commands (slave side)
//     o_mode                0 IDLE, 1 REC, 2 PLAY
//     o_loop_len            recorded length in samples
//     o_overrun             sticky: strobe arrived during an SRAM access
//     o_SRAM_*, io_SRAM_DQ  async SRAM bus, controls active-low
//     o_dbg_state           current FSM state
module loop_sram_ctrl
    import loop_pkg::*;
#(
    parameter int                ADDR_W  = 20,
    parameter logic [ADDR_W-1:0] MAX_LEN = {ADDR_W{1'b1}}
) (
    input  logic              i_AUD_BCLK,
    input  logic              i_rst_n,
    loop_sram_ctrl_if.slave   aud,
    output logic [1:0]        o_mode,
    output logic [ADDR_W-1:0] o_loop_len,
    output logic              o_overrun,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [15:0]       io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N,
    output state_e            o_dbg_state
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_e             state_q,    state_d;
    mode_e              mode_q,     mode_d;
    cmd_e               pend_q,     pend_d;
    logic [ADDR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W-1:0]  loop_len_q, loop_len_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [15:0]        dq_out_q,   dq_out_d;
    logic               dq_oe_q,    dq_oe_d;
    logic               we_n_q,     we_n_d;
    logic               ce_n_q,     ce_n_d;
    logic               oe_n_q,     oe_n_d;
    logic               bls_n_q,    bls_n_d;
    logic               v1_q,       v1_d;
    logic signed [15:0] d1_q,       d1_d;
    logic               o_valid_q,  o_valid_d;
    logic               overrun_q,  overrun_d;

    cmd_e               new_cmd;
    cmd_e               eff_cmd;
    state_e             post_cmd;
    logic [ADDR_W-1:0]  wr_next;
    logic [ADDR_W-1:0]  rd_next;
    logic signed [15:0] mix_b;
    logic signed [15:0] mix_sum;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        loop_len_d = loop_len_q;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        dq_oe_d    = dq_oe_q;
        we_n_d     = we_n_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        bls_n_d    = bls_n_q;
        v1_d       = 1'b0;
        d1_d       = d1_q;
        o_valid_d  = v1_q;
        overrun_d  = overrun_q;
        mix_b      = '0;
        post_cmd   = state_q;

        new_cmd = cmd_decode(aud.i_cmd_stop, aud.i_cmd_play, aud.i_cmd_rec);
        eff_cmd = cmd_max(new_cmd, pend_q);
        wr_next = wr_ptr_q + ONE;
        rd_next = (rd_ptr_q + ONE == loop_len_q) ? '0 : rd_ptr_q + ONE;

        // During an access a command waits for the return to REC/PLAY,
        // and a strobe cannot be serviced, so it is dropped and flagged.
        if (state_q inside {S_REC_WR, S_REC_HOLD, S_PLAY_RD}) begin
            pend_d = cmd_max(pend_q, new_cmd);
            if (aud.i_valid) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_REC, S_PLAY: begin
                pend_d = CMD_NONE;
                // Command first; the strobe below sees the resulting mode.
                case (eff_cmd)
                    CMD_STOP: post_cmd = S_IDLE;
                    CMD_PLAY: begin
                        if (state_q != S_PLAY) begin
                            if (loop_len_q != '0) begin
                                post_cmd = S_PLAY;
                                rd_ptr_d = '0;
                            end else begin
                                post_cmd = S_IDLE;
                            end
                        end
                    end
                    CMD_REC: begin
                        if (state_q != S_REC) begin
                            post_cmd   = S_REC;
                            wr_ptr_d   = '0;
                            loop_len_d = '0;
                        end
                    end
                    default: ;
                endcase

                state_d = post_cmd;
                if (aud.i_valid) begin
                    v1_d = 1'b1;
                    d1_d = aud.i_data;
                    if (post_cmd == S_REC) begin
                        addr_d   = wr_ptr_d;
                        dq_out_d = aud.i_data;
                        dq_oe_d  = 1'b1;
                        ce_n_d   = 1'b0;
                        we_n_d   = 1'b0;
                        bls_n_d  = 1'b0;
                        state_d  = S_REC_WR;
                    end else if (post_cmd == S_PLAY) begin
                        addr_d  = rd_ptr_d;
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        bls_n_d = 1'b0;
                        state_d = S_PLAY_RD;
                    end
                end
            end

            S_REC_WR: begin
                // Rising WE_N commits the write; data and address stay put
                // for one more cycle as hold time.
                we_n_d  = 1'b1;
                state_d = S_REC_HOLD;
            end

            S_REC_HOLD: begin
                dq_oe_d    = 1'b0;
                ce_n_d     = 1'b1;
                bls_n_d    = 1'b1;
                wr_ptr_d   = wr_next;
                loop_len_d = wr_next;
                if (wr_next == MAX_LEN) begin
                    state_d  = S_PLAY;
                    rd_ptr_d = '0;
                end else begin
                    state_d = S_REC;
                end
            end

            S_PLAY_RD: begin
                mix_b    = $signed(io_SRAM_DQ);
                oe_n_d   = 1'b1;
                ce_n_d   = 1'b1;
                bls_n_d  = 1'b1;
                rd_ptr_d = rd_next;
                state_d  = S_PLAY;
            end

            default: state_d = S_IDLE;
        endcase

        mode_d = mode_of(state_d);
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_IDLE;
            pend_q     <= CMD_NONE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            loop_len_q <= '0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            we_n_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            bls_n_q    <= 1'b1;
            v1_q       <= 1'b0;
            d1_q       <= '0;
            o_valid_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            loop_len_q <= loop_len_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            we_n_q     <= we_n_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            bls_n_q    <= bls_n_d;
            v1_q       <= v1_d;
            d1_q       <= d1_d;
            o_valid_q  <= o_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Second pipeline stage for every mode; the loop operand is zero
    // except while a PLAY read is being returned.
    loop_mix_sat u_mix (
        .i_AUD_BCLK (i_AUD_BCLK),
        .i_rst_n    (i_rst_n),
        .i_en       (v1_q),
        .i_a        (d1_q),
        .i_b        (mix_b),
        .o_sum      (mix_sum)
    );

    assign io_SRAM_DQ  = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign aud.o_valid = o_valid_q;
    assign aud.o_data  = mix_sum;
    assign o_mode      = mode_q;
    assign o_loop_len  = loop_len_q;
    assign o_overrun   = overrun_q;
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_WE_N = we_n_q;
    assign o_SRAM_CE_N = ce_n_q;
    assign o_SRAM_OE_N = oe_n_q;
    assign o_SRAM_LB_N = bls_n_q;
    assign o_SRAM_UB_N = bls_n_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_loop_sram_ctrl.sv
// tb_loop_sram_ctrl
//   Bench for loop_sram_ctrl with a small async SRAM model, a looper
//   reference model (mode, recorded samples, play index), an expected
//   output queue and an independent output monitor.
module tb_loop_sram_ctrl;
    import loop_pkg::*;

    localparam int MAXL = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT + SRAM model ----------------
    loop_sram_ctrl_if aud_if ();
    logic [1:0]  o_mode;
    logic [19:0] o_loop_len;
    logic        o_overrun;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;
    state_e      dbg_state;

    loop_sram_ctrl #(.ADDR_W(20), .MAX_LEN(20'd8)) dut (
        .i_AUD_BCLK  (clk),
        .i_rst_n     (rst_n),
        .aud         (aud_if.slave),
        .o_mode      (o_mode),
        .o_loop_len  (o_loop_len),
        .o_overrun   (o_overrun),
        .o_SRAM_ADDR (sram_addr),
        .io_SRAM_DQ  (sram_dq),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n),
        .o_dbg_state (dbg_state)
    );

    logic [15:0] mem [0:15];
    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[3:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[3:0]] <= sram_dq;
    end

    logic ce_low_seen = 1'b0;
    logic we_oe_clash = 1'b0;
    always @(negedge clk) begin
        if (!ce_n) ce_low_seen = 1'b1;
        if (!we_n && !oe_n) we_oe_clash = 1'b1;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Monitor: every output strobe must match the oldest expectation in
    // both value and arrival cycle.
    always @(negedge clk) begin
        if (rst_n && aud_if.o_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_o_valid got=%0d cyc=%0d", aud_if.o_data, cyc);
            end else begin
                logic [15:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (aud_if.o_data !== e || cyc != ec) begin
                    bad++;
                    $display("FAIL o_data got=%0d@%0d want=%0d@%0d",
                             $signed(aud_if.o_data), cyc, $signed(e), ec);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    int m_mode = 0;   // 0 idle, 1 rec, 2 play
    int m_len  = 0;
    int m_rd   = 0;
    int m_ovr  = 0;
    int m_loop [0:15];

    function automatic logic [15:0] clamp(input int v);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic model_cmd(input int kind);
        case (kind)
            0: if (m_mode != 1) begin m_mode = 1; m_len = 0; end
            1: if (m_mode != 2) begin
                   if (m_len > 0) begin m_mode = 2; m_rd = 0; end
                   else m_mode = 0;
               end
            default: m_mode = 0;
        endcase
    endtask

    task automatic model_strobe(input int d);
        case (m_mode)
            1: begin
                exp_q.push_back(16'(d));
                m_loop[m_len] = d;
                m_len++;
                if (m_len == MAXL) begin m_mode = 2; m_rd = 0; end
            end
            2: begin
                exp_q.push_back(clamp(d + m_loop[m_rd]));
                m_rd = (m_rd + 1) % m_len;
            end
            default: exp_q.push_back(16'(d));
        endcase
        exp_cyc_q.push_back(cyc + 2);
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input int kind);
        @(posedge clk); #1;
        aud_if.i_cmd_rec  = (kind == 0);
        aud_if.i_cmd_play = (kind == 1);
        aud_if.i_cmd_stop = (kind == 2);
        model_cmd(kind);
        @(posedge clk); #1;
        aud_if.i_cmd_rec  = 1'b0;
        aud_if.i_cmd_play = 1'b0;
        aud_if.i_cmd_stop = 1'b0;
    endtask

    task automatic issue_strobe(input int d, input int gap);
        @(posedge clk); #1;
        aud_if.i_valid = 1'b1;
        aud_if.i_data  = 16'(d);
        model_strobe(d);
        @(posedge clk); #1;
        aud_if.i_valid = 1'b0;
        idle(gap);
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_mode"}, int'(o_mode), m_mode);
        check({tag, "_len"}, int'(o_loop_len), m_len);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        aud_if.i_valid    = 1'b0;
        aud_if.i_data     = '0;
        aud_if.i_cmd_rec  = 1'b0;
        aud_if.i_cmd_play = 1'b0;
        aud_if.i_cmd_stop = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mode", int'(o_mode), 0);
        check("rst_len", int'(o_loop_len), 0);
        check("rst_overrun", int'(o_overrun), 0);
        check("rst_o_valid", int'(aud_if.o_valid), 0);
        check("rst_o_data", int'(aud_if.o_data), 0);
        check("rst_addr", int'(sram_addr), 0);
        check("rst_ctrl", int'({we_n, ce_n, oe_n, lb_n, ub_n}), 31);
        rst_n = 1'b1;
        idle(2);

        // Record 4 samples slowly, then loop them back with silent input.
        issue_cmd(0);
        check_state("rec_start");
        issue_strobe(100, 62);
        issue_strobe(200, 62);
        issue_strobe(300, 62);
        issue_strobe(400, 62);
        issue_cmd(1);
        check_state("play_start");
        check("loop_len_4", int'(o_loop_len), 4);
        for (int i = 0; i < 6; i++) issue_strobe(0, $urandom_range(4, 10));

        // Random takes: record, play with live input, stop, resume from idle.
        for (int it = 0; it < 4; it++) begin
            int n;
            n = $urandom_range(1, 6);
            issue_cmd(0);
            for (int i = 0; i < n; i++) issue_strobe(rand_sample(), $urandom_range(4, 9));
            issue_cmd(1);
            check_state("rand_play");
            for (int i = 0; i < int'($urandom_range(3, 10)); i++)
                issue_strobe(rand_sample(), $urandom_range(4, 9));
            issue_cmd(2);
            check_state("rand_stop");
            issue_cmd(1);
            check_state("rand_resume");
            issue_strobe(rand_sample(), 5);
        end

        // Saturation at both rails.
        issue_cmd(0);
        issue_strobe(30000, 5);
        issue_strobe(-30000, 5);
        issue_cmd(1);
        issue_strobe(10000, 5);
        issue_strobe(-10000, 5);
        check("sat_model_hi", int'(clamp(30000 + 10000)), 32767);

        // Auto-close when the take reaches MAX_LEN.
        issue_cmd(0);
        for (int i = 0; i < MAXL; i++) begin
            issue_strobe(rand_sample(), 5);
            if (i == MAXL - 2) check("autoclose_not_yet", int'(o_mode), 1);
        end
        check_state("autoclose");
        @(posedge clk); #1;
        aud_if.i_valid = 1'b1;
        aud_if.i_data  = 16'(123);
        model_strobe(123);
        @(posedge clk); #1;
        aud_if.i_valid = 1'b0;
        check("autoclose_rd_addr", int'(sram_addr), 0);
        check("autoclose_rd_oe", int'(oe_n), 0);
        idle(5);

        // Deferred stop plus a colliding strobe while the read is in flight.
        check("ovr_before", int'(o_overrun), 0);
        @(posedge clk); #1;
        aud_if.i_valid = 1'b1;
        aud_if.i_data  = 16'(-5);
        model_strobe(-5);
        @(posedge clk); #1;
        aud_if.i_data     = 16'(777);
        aud_if.i_cmd_stop = 1'b1;
        @(posedge clk); #1;
        aud_if.i_valid    = 1'b0;
        aud_if.i_cmd_stop = 1'b0;
        m_ovr = 1;
        check("deferred_still_play", int'(o_mode), 2);
        model_cmd(2);
        idle(3);
        check_state("deferred_idle");
        check("ovr_after", int'(o_overrun), m_ovr);

        // Empty record: rec then play with nothing captured.
        ce_low_seen = 1'b0;
        issue_cmd(0);
        issue_cmd(1);
        idle(3);
        check_state("empty_rec");
        check("empty_ce_low", int'(ce_low_seen), 0);
        issue_cmd(1);
        check_state("idle_play_empty");
        for (int i = 0; i < 3; i++) issue_strobe(rand_sample(), $urandom_range(1, 4));
        idle(4);

        // Reset in the middle of a write.
        issue_cmd(0);
        @(posedge clk); #1;
        aud_if.i_valid = 1'b1;
        aud_if.i_data  = 16'(55);
        @(posedge clk); #1;
        aud_if.i_valid = 1'b0;
        check("midwr_state", int'(dbg_state), int'(S_REC_WR));
        check("midwr_we", int'(we_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midwr_rst_we_ce", int'({we_n, ce_n}), 3);
        check("midwr_rst_oe_bl", int'({oe_n, lb_n, ub_n}), 7);
        m_mode = 0; m_len = 0; m_ovr = 0;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check_state("after_rst");
        check("after_rst_ovr", int'(o_overrun), m_ovr);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        idle(2);
        check("drain", exp_q.size(), 0);
        check("we_oe_clash", int'(we_oe_clash), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
